// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pkg
// Purpose  : Shared definitions for the reorder buffer:
//            - default ROB depth (log2) and data width
//            - instruction-type codes carried in each entry
//            - redirect address helper used on branch mispredict
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

  localparam int ROB_SIZE_WIDTH_DEFAULT = 3;
  localparam int XLEN                   = 32;

  // Instruction classes; the encodings reuse the RISC-V major opcodes so the
  // decoder can forward its opcode field unchanged.
  typedef enum logic [6:0] {
    I_TYPE = 7'b0010011,
    R_TYPE = 7'b0110011,
    B_TYPE = 7'b1100011,
    S_TYPE = 7'b0100011,
    L_TYPE = 7'b0000011,
    U_TYPE = 7'b0110111,
    J_TYPE = 7'b1101111
  } instr_type_e;

  // Refetch address after a mispredicted branch: the real outcome decides
  // between the taken target and the fall-through (wraps at 32 bits).
  function automatic logic [XLEN-1:0] redirect_pc(input logic            taken,
                                                  input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] target);
    return taken ? target : (pc + 32'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_query_port.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_query_port
// Purpose  : One decoder operand-lookup port of the reorder buffer.
//            Returns the value of a ROB entry when it is known, either from
//            the stored entry or bypassed from a result broadcast in the
//            current cycle (LSB broadcast has priority over RS broadcast).
//            Purely combinational.
// Ports    : qry_id        in   lookup tag
//            entry_ready   in   per-entry ready bits
//            entry_value   in   per-entry stored values
//            rs_*/lsb_*    in   result broadcasts of this cycle
//            qry_ok        out  value available
//            qry_val       out  value (0 when not available)
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer_query_port
  import reorder_buffer_pkg::*;
#(
  parameter  int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEFAULT,
  localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH
) (
  input  logic [ROB_SIZE_WIDTH-1:0]          qry_id,
  input  logic [ROB_SIZE-1:0]                entry_ready,
  input  logic [ROB_SIZE-1:0][XLEN-1:0]      entry_value,
  input  logic                               rs_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]          rs_rob_id,
  input  logic [XLEN-1:0]                    rs_value,
  input  logic                               lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]          lsb_rob_id,
  input  logic [XLEN-1:0]                    lsb_value,
  output logic                               qry_ok,
  output logic [XLEN-1:0]                    qry_val
);

  always_comb begin
    qry_ok  = 1'b0;
    qry_val = '0;
    if (lsb_ready && (lsb_rob_id == qry_id)) begin
      qry_ok  = 1'b1;
      qry_val = lsb_value;
    end else if (rs_ready && (rs_rob_id == qry_id)) begin
      qry_ok  = 1'b1;
      qry_val = rs_value;
    end else if (entry_ready[qry_id]) begin
      qry_ok  = 1'b1;
      qry_val = entry_value[qry_id];
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular reorder buffer. Allocates one entry per issued
//            instruction, captures RS/LSB result broadcasts by rob id,
//            retires at most one entry per cycle in program order, answers
//            two decoder operand lookups and flushes on branch mispredict.
// Config   : ROB_PERF_EN - when defined adds perf_commits/perf_mispredicts
//            wrapping counters; otherwise they do not exist.
// Ports    : clk, rst (async, active-low), rdy (global enable)
//            rob_full                  buffer has no free entry
//            issue_*                   allocation request at tail
//            tail_id                   id the next issue receives
//            rs_* / lsb_*              result broadcasts
//            qry_id1/2 -> qry_ok/val   operand lookups (combinational)
//            commit_*                  retirement, registered, 1-cycle valid
//            rob_clear, clear_pc       registered flush pulse + refetch pc
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEFAULT
) (
`ifdef ROB_PERF_EN
  output logic [31:0]               perf_commits,
  output logic [31:0]               perf_mispredicts,
`endif
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  output logic                      rob_full,
  input  logic                      issue_valid,
  input  logic [6:0]                issue_type,
  input  logic [4:0]                issue_rd,
  input  logic [XLEN-1:0]           issue_pc,
  input  logic [XLEN-1:0]           issue_target,
  input  logic                      issue_pred,
  input  logic                      issue_ready,
  input  logic [XLEN-1:0]           issue_value,
  output logic [ROB_SIZE_WIDTH-1:0] tail_id,
  input  logic                      rs_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
  input  logic [XLEN-1:0]           rs_value,
  input  logic                      lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [XLEN-1:0]           lsb_value,
  input  logic [ROB_SIZE_WIDTH-1:0] qry_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] qry_id2,
  output logic                      qry_ok1,
  output logic                      qry_ok2,
  output logic [XLEN-1:0]           qry_val1,
  output logic [XLEN-1:0]           qry_val2,
  output logic                      commit_valid,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic [4:0]                commit_rd,
  output logic [XLEN-1:0]           commit_value,
  output logic                      rob_clear,
  output logic [XLEN-1:0]           clear_pc
);

  localparam int W        = ROB_SIZE_WIDTH;
  localparam int ROB_SIZE = 1 << W;
  localparam int CW       = W + 1;

  // Entry storage, one flat array per field, indexed by rob id.
  logic [ROB_SIZE-1:0]            busy_q,   busy_d;
  logic [ROB_SIZE-1:0]            ready_q,  ready_d;
  logic [ROB_SIZE-1:0]            pred_q,   pred_d;
  logic [ROB_SIZE-1:0][XLEN-1:0]  value_q,  value_d;
  logic [ROB_SIZE-1:0][XLEN-1:0]  pc_q,     pc_d;
  logic [ROB_SIZE-1:0][XLEN-1:0]  target_q, target_d;
  logic [ROB_SIZE-1:0][4:0]       rd_q,     rd_d;
  logic [ROB_SIZE-1:0][6:0]       type_q,   type_d;

  logic [W-1:0]     head_q,  head_d;
  logic [W-1:0]     tail_q,  tail_d;
  logic [CW-1:0]    count_q, count_d;

  // A mispredicted branch retires at edge N; flush_pending marks the cycle
  // between N and N+1 in which nothing issues or retires, and the flush
  // itself (with rob_clear) happens at N+1.
  logic             flush_pending_q, flush_pending_d;
  logic [XLEN-1:0]  flush_pc_q,      flush_pc_d;

  logic             commit_valid_q,  commit_valid_d;
  logic [W-1:0]     commit_rob_id_q, commit_rob_id_d;
  logic [4:0]       commit_rd_q,     commit_rd_d;
  logic [XLEN-1:0]  commit_value_q,  commit_value_d;
  logic             rob_clear_q,     rob_clear_d;
  logic [XLEN-1:0]  clear_pc_q,      clear_pc_d;

  logic             do_issue;
  logic             do_commit;
  logic             head_is_branch;
  logic             head_taken;
  logic             head_mispred;

  assign rob_full = (count_q == CW'(ROB_SIZE));

  always_comb begin
    busy_d          = busy_q;
    ready_d         = ready_q;
    pred_d          = pred_q;
    value_d         = value_q;
    pc_d            = pc_q;
    target_d        = target_q;
    rd_d            = rd_q;
    type_d          = type_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    flush_pending_d = 1'b0;
    flush_pc_d      = flush_pc_q;
    commit_valid_d  = 1'b0;
    commit_rob_id_d = commit_rob_id_q;
    commit_rd_d     = commit_rd_q;
    commit_value_d  = commit_value_q;
    rob_clear_d     = 1'b0;
    clear_pc_d      = clear_pc_q;
    do_issue        = 1'b0;
    do_commit       = 1'b0;
    head_is_branch  = (type_q[head_q] == B_TYPE);
    head_taken      = value_q[head_q][0];
    head_mispred    = 1'b0;

    if (flush_pending_q) begin
      // Everything younger than the mispredicted branch is discarded,
      // including any issue attempted in this cycle.
      busy_d      = '0;
      ready_d     = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      rob_clear_d = 1'b1;
      clear_pc_d  = flush_pc_q;
    end else begin
      do_issue  = issue_valid && !rob_full;
      do_commit = busy_q[head_q] && ready_q[head_q];

      if (do_issue) begin
        busy_d[tail_q]   = 1'b1;
        ready_d[tail_q]  = issue_ready;
        value_d[tail_q]  = issue_value;
        type_d[tail_q]   = issue_type;
        rd_d[tail_q]     = issue_rd;
        pc_d[tail_q]     = issue_pc;
        target_d[tail_q] = issue_target;
        pred_d[tail_q]   = issue_pred;
        tail_d           = tail_q + W'(1);
      end

      // Captures are applied after the issue write so a broadcast aimed at
      // the entry being allocated wins over issue_ready/issue_value, and the
      // LSB capture is applied last so it wins over RS on a shared tag.
      if (rs_ready && (busy_q[rs_rob_id] || (do_issue && (rs_rob_id == tail_q)))) begin
        ready_d[rs_rob_id] = 1'b1;
        value_d[rs_rob_id] = rs_value;
      end
      if (lsb_ready && (busy_q[lsb_rob_id] || (do_issue && (lsb_rob_id == tail_q)))) begin
        ready_d[lsb_rob_id] = 1'b1;
        value_d[lsb_rob_id] = lsb_value;
      end

      if (do_commit) begin
        head_mispred    = head_is_branch && (head_taken != pred_q[head_q]);
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + W'(1);
        commit_valid_d  = 1'b1;
        commit_rob_id_d = head_q;
        commit_value_d  = value_q[head_q];
        // Branches never write the register file.
        commit_rd_d     = head_is_branch ? 5'd0 : rd_q[head_q];
        if (head_mispred) begin
          flush_pending_d = 1'b1;
          flush_pc_d      = redirect_pc(head_taken, pc_q[head_q], target_q[head_q]);
        end
      end

      count_d = count_q + CW'(do_issue) - CW'(do_commit);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q          <= '0;
      ready_q         <= '0;
      pred_q          <= '0;
      value_q         <= '0;
      pc_q            <= '0;
      target_q        <= '0;
      rd_q            <= '0;
      type_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
      flush_pc_q      <= '0;
      commit_valid_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      rob_clear_q     <= 1'b0;
      clear_pc_q      <= '0;
    end else if (rdy) begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      pred_q          <= pred_d;
      value_q         <= value_d;
      pc_q            <= pc_d;
      target_q        <= target_d;
      rd_q            <= rd_d;
      type_q          <= type_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      flush_pending_q <= flush_pending_d;
      flush_pc_q      <= flush_pc_d;
      commit_valid_q  <= commit_valid_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_rd_q     <= commit_rd_d;
      commit_value_q  <= commit_value_d;
      rob_clear_q     <= rob_clear_d;
      clear_pc_q      <= clear_pc_d;
    end
  end

  assign tail_id       = tail_q;
  assign commit_valid  = commit_valid_q;
  assign commit_rob_id = commit_rob_id_q;
  assign commit_rd     = commit_rd_q;
  assign commit_value  = commit_value_q;
  assign rob_clear     = rob_clear_q;
  assign clear_pc      = clear_pc_q;

`ifdef ROB_PERF_EN
  logic [31:0] perf_commits_q,     perf_commits_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  always_comb begin
    perf_commits_d     = perf_commits_q     + {31'd0, do_commit};
    perf_mispredicts_d = perf_mispredicts_q + {31'd0, head_mispred};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_commits_q     <= '0;
      perf_mispredicts_q <= '0;
    end else if (rdy) begin
      perf_commits_q     <= perf_commits_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_commits     = perf_commits_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

  reorder_buffer_query_port #(
    .ROB_SIZE_WIDTH (W)
  ) u_qry1 (
    .qry_id      (qry_id1),
    .entry_ready (ready_q),
    .entry_value (value_q),
    .rs_ready    (rs_ready),
    .rs_rob_id   (rs_rob_id),
    .rs_value    (rs_value),
    .lsb_ready   (lsb_ready),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_value   (lsb_value),
    .qry_ok      (qry_ok1),
    .qry_val     (qry_val1)
  );

  reorder_buffer_query_port #(
    .ROB_SIZE_WIDTH (W)
  ) u_qry2 (
    .qry_id      (qry_id2),
    .entry_ready (ready_q),
    .entry_value (value_q),
    .rs_ready    (rs_ready),
    .rs_rob_id   (rs_rob_id),
    .rs_value    (rs_value),
    .lsb_ready   (lsb_ready),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_value   (lsb_value),
    .qry_ok      (qry_ok2),
    .qry_val     (qry_val2)
  );

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Directed self-checking bench for reorder_buffer (8 entries).
//            Covers reset, full/wrap, in-order retirement, branch flush,
//            query bypass, rdy hold and the optional ROB_PERF_EN counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int W = 3;

  logic         clk, rst, rdy;
  logic         rob_full;
  logic         issue_valid, issue_pred, issue_ready;
  logic [6:0]   issue_type;
  logic [4:0]   issue_rd;
  logic [31:0]  issue_pc, issue_target, issue_value;
  logic [W-1:0] tail_id;
  logic         rs_ready, lsb_ready;
  logic [W-1:0] rs_rob_id, lsb_rob_id;
  logic [31:0]  rs_value, lsb_value;
  logic [W-1:0] qry_id1, qry_id2;
  logic         qry_ok1, qry_ok2;
  logic [31:0]  qry_val1, qry_val2;
  logic         commit_valid;
  logic [W-1:0] commit_rob_id;
  logic [4:0]   commit_rd;
  logic [31:0]  commit_value;
  logic         rob_clear;
  logic [31:0]  clear_pc;
`ifdef ROB_PERF_EN
  logic [31:0]  perf_commits, perf_mispredicts;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  reorder_buffer #(.ROB_SIZE_WIDTH(W)) dut (
`ifdef ROB_PERF_EN
    .perf_commits     (perf_commits),
    .perf_mispredicts (perf_mispredicts),
`endif
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .rob_full      (rob_full),
    .issue_valid   (issue_valid),
    .issue_type    (issue_type),
    .issue_rd      (issue_rd),
    .issue_pc      (issue_pc),
    .issue_target  (issue_target),
    .issue_pred    (issue_pred),
    .issue_ready   (issue_ready),
    .issue_value   (issue_value),
    .tail_id       (tail_id),
    .rs_ready      (rs_ready),
    .rs_rob_id     (rs_rob_id),
    .rs_value      (rs_value),
    .lsb_ready     (lsb_ready),
    .lsb_rob_id    (lsb_rob_id),
    .lsb_value     (lsb_value),
    .qry_id1       (qry_id1),
    .qry_id2       (qry_id2),
    .qry_ok1       (qry_ok1),
    .qry_ok2       (qry_ok2),
    .qry_val1      (qry_val1),
    .qry_val2      (qry_val2),
    .commit_valid  (commit_valid),
    .commit_rob_id (commit_rob_id),
    .commit_rd     (commit_rd),
    .commit_value  (commit_value),
    .rob_clear     (rob_clear),
    .clear_pc      (clear_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_type = R_TYPE; issue_rd = 0; issue_pc = 0;
    issue_target = 0; issue_pred = 0; issue_ready = 0; issue_value = 0;
    rs_ready = 0; rs_rob_id = 0; rs_value = 0;
    lsb_ready = 0; lsb_rob_id = 0; lsb_value = 0;
    qry_id1 = 0; qry_id2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy = 1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    tick();
  endtask

  // Presents one issue request for a single clock edge.
  task automatic issue(input logic [6:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pred, input logic rdy_at_issue,
                       input logic [31:0] val);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_pc = pc;
    issue_target = tgt; issue_pred = pred; issue_ready = rdy_at_issue; issue_value = val;
    tick();
    issue_valid = 0;
  endtask

  initial begin
    rst = 0;
    rdy = 1;
    idle_inputs();

    // ---- 1: asynchronous reset with entries in flight ----
    do_reset();
    check_eq("t1_reset_full", rob_full, 0);
    check_eq("t1_reset_tail", tail_id, 0);
    check_eq("t1_reset_commit", commit_valid, 0);
    check_eq("t1_reset_clear", rob_clear, 0);
    for (int i = 0; i < 3; i++) issue(R_TYPE, 5'(i + 1), 0, 0, 0, 0, 0);
    rs_ready = 1; rs_rob_id = 0; rs_value = 7;
    issue(R_TYPE, 4, 0, 0, 0, 0, 0);
    rs_ready = 0;
    tick();
    check_eq("t1_pre_commit_valid", commit_valid, 1);
    check_eq("t1_pre_commit_value", commit_value, 7);
    #2 rst = 0;
    #1;
    check_eq("t1_async_full", rob_full, 0);
    check_eq("t1_async_tail", tail_id, 0);
    check_eq("t1_async_commit", commit_valid, 0);
    check_eq("t1_async_value", commit_value, 0);
    check_eq("t1_async_clear", rob_clear, 0);
    @(posedge clk); #1;
    rst = 1;
    // id1 was busy before reset; a broadcast to it must now be ignored
    rs_ready = 1; rs_rob_id = 1; rs_value = 9;
    tick();
    rs_ready = 0;
    tick();
    check_eq("t1_no_ghost_commit", commit_valid, 0);
    check_eq("t1_no_ghost_qry", qry_ok1, 0);

    // ---- 2: fill, ignored 9th issue, wrap ----
    do_reset();
    for (int i = 0; i < 8; i++) issue(R_TYPE, 5'(i + 1), 0, 0, 0, 0, 0);
    check_eq("t2_full", rob_full, 1);
    check_eq("t2_tail_wrap", tail_id, 0);
    issue(R_TYPE, 31, 0, 0, 0, 1, 32'hBAD);
    check_eq("t2_full_after_9th", rob_full, 1);
    check_eq("t2_tail_after_9th", tail_id, 0);
    rs_ready = 1; rs_rob_id = 0; rs_value = 5;
    tick();
    rs_ready = 0;
    check_eq("t2_no_early_commit", commit_valid, 0);
    qry_id1 = 0;
    #1;
    check_eq("t2_qry_stored_ok", qry_ok1, 1);
    check_eq("t2_qry_stored_val", qry_val1, 5);
    tick();
    check_eq("t2_commit_valid", commit_valid, 1);
    check_eq("t2_commit_id", commit_rob_id, 0);
    check_eq("t2_commit_value", commit_value, 5);
    check_eq("t2_commit_rd", commit_rd, 1);
    check_eq("t2_full_dropped", rob_full, 0);
    check_eq("t2_tail_after", tail_id, 0);

    // ---- 3: out-of-order completion, in-order retirement ----
    do_reset();
    for (int i = 0; i < 3; i++) issue(R_TYPE, 5'(i + 1), 0, 0, 0, 0, 0);
    rs_ready = 1; rs_rob_id = 2; rs_value = 30;
    tick();
    rs_ready = 0; lsb_ready = 1; lsb_rob_id = 1; lsb_value = 20;
    tick();
    lsb_ready = 0; rs_ready = 1; rs_rob_id = 0; rs_value = 10;
    tick();
    rs_ready = 0;
    check_eq("t3_no_commit_yet", commit_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_commit_valid", commit_valid, 1);
      check_eq("t3_commit_id", 32'(commit_rob_id), 32'(i));
      check_eq("t3_commit_value", commit_value, 32'(10 * (i + 1)));
      check_eq("t3_commit_rd", commit_rd, 5'(i + 1));
    end
    // broadcast to the entry being issued overrides issue_ready=0
    rs_ready = 1; rs_rob_id = 3; rs_value = 77;
    issue(R_TYPE, 4, 0, 0, 0, 0, 0);
    rs_ready = 0;
    check_eq("t3_issue_bcast_nocommit", commit_valid, 0);
    tick();
    check_eq("t3_issue_bcast_commit", commit_valid, 1);
    check_eq("t3_issue_bcast_value", commit_value, 77);

    // ---- 4: mispredicted branch flush ----
    do_reset();
    for (int i = 0; i < 3; i++) issue(R_TYPE, 5'(i + 1), 0, 0, 0, 0, 0);
    issue(B_TYPE, 0, 32'h100, 32'h200, 1, 0, 0);
    for (int i = 4; i < 7; i++) issue(R_TYPE, 5'(i + 6), 0, 0, 0, 1, 32'(64 + i));
    rs_ready = 1; rs_rob_id = 0; rs_value = 10;
    lsb_ready = 1; lsb_rob_id = 1; lsb_value = 11;
    tick();
    rs_rob_id = 3; rs_value = 0;
    lsb_rob_id = 2; lsb_value = 12;
    tick();
    rs_ready = 0; lsb_ready = 0;
    check_eq("t4_commit0_id", commit_rob_id, 0);
    tick();
    check_eq("t4_commit1_id", commit_rob_id, 1);
    tick();
    check_eq("t4_commit2_value", commit_value, 12);
    tick();
    check_eq("t4_br_commit_valid", commit_valid, 1);
    check_eq("t4_br_commit_id", commit_rob_id, 3);
    check_eq("t4_br_commit_rd", commit_rd, 0);
    check_eq("t4_br_no_clear_yet", rob_clear, 0);
    // issue attempted in the flush cycle must be dropped
    issue(R_TYPE, 20, 0, 0, 0, 1, 32'h99);
    check_eq("t4_clear", rob_clear, 1);
    check_eq("t4_clear_pc", clear_pc, 32'h104);
    check_eq("t4_no_commit_4", commit_valid, 0);
    check_eq("t4_tail_reset", tail_id, 0);
`ifdef ROB_PERF_EN
    check_eq("t6_perf_commits", perf_commits, 4);
    check_eq("t6_perf_mispredicts", perf_mispredicts, 1);
`endif
    tick();
    check_eq("t4_clear_pulse_end", rob_clear, 0);
    check_eq("t4_no_commit_after", commit_valid, 0);
    check_eq("t4_tail_still_0", tail_id, 0);
    issue(R_TYPE, 9, 0, 0, 0, 1, 32'h55);
    check_eq("t4_tail_after_issue", tail_id, 1);
    // rdy low: nothing moves, even a pending commit and a new issue
    rdy = 0;
    issue_valid = 1; issue_rd = 3; issue_ready = 1; issue_value = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_rdy_hold_commit", commit_valid, 0);
      check_eq("t6_rdy_hold_tail", tail_id, 1);
`ifdef ROB_PERF_EN
      check_eq("t6_rdy_hold_perf_c", perf_commits, 4);
      check_eq("t6_rdy_hold_perf_m", perf_mispredicts, 1);
`endif
    end
    issue_valid = 0;
    rdy = 1;
    tick();
    check_eq("t6_resume_commit", commit_valid, 1);
    check_eq("t6_resume_value", commit_value, 32'h55);
    check_eq("t6_resume_rd", commit_rd, 9);
`ifdef ROB_PERF_EN
    check_eq("t6_perf_commits_5", perf_commits, 5);
    check_eq("t6_perf_mispredicts_1", perf_mispredicts, 1);
`endif

    // ---- 5: queries, bypass, lsb priority, correct branch ----
    do_reset();
    issue(B_TYPE, 7, 32'h300, 32'h400, 0, 0, 0);
    for (int i = 1; i < 6; i++) issue(R_TYPE, 5'(i), 0, 0, 0, 0, 0);
    qry_id1 = 4; qry_id2 = 5;
    lsb_ready = 1; lsb_rob_id = 4; lsb_value = 32'hDEAD;
    #1;
    check_eq("t5_bypass_ok", qry_ok1, 1);
    check_eq("t5_bypass_val", qry_val1, 32'hDEAD);
    check_eq("t5_notready_ok", qry_ok2, 0);
    check_eq("t5_notready_val", qry_val2, 0);
    tick();
    rs_ready = 1; rs_rob_id = 5; rs_value = 32'h1111;
    lsb_rob_id = 5; lsb_value = 32'h2222;
    #1;
    check_eq("t5_bypass_lsb_prio", qry_val2, 32'h2222);
    tick();
    rs_ready = 0; lsb_ready = 0;
    #1;
    check_eq("t5_stored4_ok", qry_ok1, 1);
    check_eq("t5_stored4_val", qry_val1, 32'hDEAD);
    check_eq("t5_stored5_val", qry_val2, 32'h2222);
    rs_ready = 1; rs_rob_id = 7; rs_value = 32'h99;
    tick();
    rs_ready = 0;
    qry_id1 = 7;
    #1;
    check_eq("t5_nonbusy_ignored", qry_ok1, 0);
    rs_ready = 1; rs_rob_id = 0; rs_value = 0;
    tick();
    rs_ready = 0;
    tick();
    check_eq("t5_good_br_commit", commit_valid, 1);
    check_eq("t5_good_br_rd", commit_rd, 0);
    tick();
    check_eq("t5_good_br_no_clear", rob_clear, 0);
    check_eq("t5_good_br_tail", tail_id, 6);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
